// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that turns one byte-level I2C request into the IICMB command
// sequence (set-bus, start, address, data, stop) with irq completion and timeout recovery.
module i2cmb_wb_sequencer #(
    parameter int LEN_W          = 8,
    parameter int BUS_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             cyc_o,
    output logic             stb_o,
    input  logic             ack_i,
    output logic [1:0]       adr_o,
    output logic             we_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             irq_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [BUS_W-1:0] req_bus,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic [2:0]       status,
    output logic             busy
);
    // INIT/RST1: CSR=C0 | RST0: CSR=00 | DPR_WR/CMD_WR/WAIT_IRQ/CMD_RD: one command step
    // WR_BYTE: wait wr_valid | DPR_RD: fetch read byte | DONE: report status
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_DPR_WR   = 4'd2;
    localparam logic [3:0] S_CMD_WR   = 4'd3;
    localparam logic [3:0] S_WAIT_IRQ = 4'd4;
    localparam logic [3:0] S_CMD_RD   = 4'd5;
    localparam logic [3:0] S_WR_BYTE  = 4'd6;
    localparam logic [3:0] S_DPR_RD   = 4'd7;
    localparam logic [3:0] S_RST0     = 4'd8;
    localparam logic [3:0] S_RST1     = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [2:0] P_BUS   = 3'd0;
    localparam logic [2:0] P_START = 3'd1;
    localparam logic [2:0] P_ADDR  = 3'd2;
    localparam logic [2:0] P_DATA  = 3'd3;
    localparam logic [2:0] P_STOP  = 3'd4;

    localparam logic [1:0] A_CSR  = 2'd0;
    localparam logic [1:0] A_DPR  = 2'd1;
    localparam logic [1:0] A_CMDR = 2'd2;

    logic [3:0]       state;
    logic [2:0]       phase;
    logic [7:0]       cmd_c;
    logic [7:0]       dpr_d;
    logic             rw_q;
    logic [6:0]       addr_q;
    logic [LEN_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;

    logic       op_act;
    logic [1:0] op_adr;
    logic       op_we;
    logic [7:0] op_dat;
    logic       op_ack;

    always_comb begin
        op_act = 1'b1;
        op_adr = A_CSR;
        op_we  = 1'b1;
        op_dat = 8'h00;
        case (state)
            S_INIT, S_RST1: op_dat = 8'hC0;
            S_RST0:         op_dat = 8'h00;
            S_DPR_WR: begin op_adr = A_DPR;  op_dat = dpr_d; end
            S_CMD_WR: begin op_adr = A_CMDR; op_dat = cmd_c; end
            S_CMD_RD: begin op_adr = A_CMDR; op_we  = 1'b0;  end
            S_DPR_RD: begin op_adr = A_DPR;  op_we  = 1'b0;  end
            default:  op_act = 1'b0;
        endcase
    end

    assign op_ack    = op_act && cyc_o && ack_i;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE) && (state != S_INIT);
    assign done      = (state == S_DONE);
    assign wr_ready  = (state == S_WR_BYTE) && wr_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_INIT;  phase <= P_BUS;
            cyc_o <= 1'b0;    stb_o <= 1'b0;  we_o <= 1'b0;
            adr_o <= 2'd0;    dat_o <= 8'h00;
            rd_data <= 8'h00; rd_valid <= 1'b0; status <= 3'd0;
            cmd_c <= 8'h00;   dpr_d <= 8'h00;
            rw_q <= 1'b0;     addr_q <= 7'd0; cnt <= '0; tmo <= '0;
        end else begin
            rd_valid <= 1'b0;
            // Launch only from an idle bus, which guarantees a gap cycle between ops
            if (op_act && !cyc_o) begin
                cyc_o <= 1'b1; stb_o <= 1'b1;
                adr_o <= op_adr; we_o <= op_we; dat_o <= op_dat;
            end
            if (op_ack) begin
                cyc_o <= 1'b0; stb_o <= 1'b0; we_o <= 1'b0;
            end
            case (state)
                S_INIT: if (op_ack) state <= S_IDLE;
                S_IDLE: if (req_valid) begin
                    rw_q   <= req_rw;
                    addr_q <= req_addr;
                    cnt    <= req_len;
                    status <= 3'd0;
                    phase  <= P_BUS;
                    dpr_d  <= 8'(req_bus);
                    cmd_c  <= 8'h06;
                    state  <= S_DPR_WR;
                end
                S_DPR_WR: if (op_ack) state <= S_CMD_WR;
                S_CMD_WR: if (op_ack) begin
                    tmo   <= TMO_W'(TIMEOUT_CYCLES);
                    state <= S_WAIT_IRQ;
                end
                S_WAIT_IRQ: begin
                    if (irq_i) state <= S_CMD_RD;
                    else if (tmo == '0) begin
                        status <= 3'd5;
                        state  <= S_RST0;
                    end else tmo <= tmo - TMO_W'(1);
                end
                S_CMD_RD: if (op_ack) begin
                    if (dat_i[5]) begin
                        status <= 3'd3; state <= S_DONE;
                    end else if (dat_i[4]) begin
                        status <= 3'd4; state <= S_DONE;
                    end else if (dat_i[6] && (phase == P_ADDR || (phase == P_DATA && !rw_q))) begin
                        status <= (phase == P_ADDR) ? 3'd1 : 3'd2;
                        phase <= P_STOP; cmd_c <= 8'h05; state <= S_CMD_WR;
                    end else begin
                        case (phase)
                            P_BUS: begin
                                phase <= P_START; cmd_c <= 8'h04; state <= S_CMD_WR;
                            end
                            P_START: begin
                                phase <= P_ADDR; cmd_c <= 8'h01;
                                dpr_d <= {addr_q, rw_q}; state <= S_DPR_WR;
                            end
                            P_ADDR: begin
                                if (cnt == '0) begin
                                    phase <= P_STOP; cmd_c <= 8'h05; state <= S_CMD_WR;
                                end else begin
                                    phase <= P_DATA;
                                    if (rw_q) begin
                                        cmd_c <= (cnt == LEN_W'(1)) ? 8'h03 : 8'h02;
                                        state <= S_CMD_WR;
                                    end else state <= S_WR_BYTE;
                                end
                            end
                            P_DATA: begin
                                if (rw_q) begin
                                    if (cnt != '0) cnt <= cnt - LEN_W'(1);
                                    state <= S_DPR_RD;
                                end else if (cnt == '0) begin
                                    phase <= P_STOP; cmd_c <= 8'h05; state <= S_CMD_WR;
                                end else state <= S_WR_BYTE;
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_WR_BYTE: if (wr_valid) begin
                    dpr_d <= wr_data;
                    cmd_c <= 8'h01;
                    if (cnt != '0) cnt <= cnt - LEN_W'(1);
                    state <= S_DPR_WR;
                end
                S_DPR_RD: if (op_ack) begin
                    rd_data  <= dat_i;
                    rd_valid <= 1'b1;
                    if (cnt == '0) begin
                        phase <= P_STOP; cmd_c <= 8'h05;
                    end else cmd_c <= (cnt == LEN_W'(1)) ? 8'h03 : 8'h02;
                    state <= S_CMD_WR;
                end
                S_RST0: if (op_ack) state <= S_RST1;
                S_RST1: if (op_ack) state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: IICMB register model on the Wishbone side, table vectors,
// hand-built reset/timeout cases and random requests checked against a transaction model.
module tb_i2cmb_wb_sequencer;
    logic clk = 1'b0;
    logic rst_i, cyc_o, stb_o, ack_i, we_o, irq_i;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;
    logic req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_len;
    logic [3:0] req_bus;
    logic [7:0] wr_data, rd_data;
    logic wr_valid, wr_ready, rd_valid, done, busy;
    logic [2:0] status;

    i2cmb_wb_sequencer #(.LEN_W(8), .BUS_W(4), .TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .rst_i(rst_i), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i),
        .adr_o(adr_o), .we_o(we_o), .dat_o(dat_o), .dat_i(dat_i), .irq_i(irq_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
        .req_len(req_len), .req_bus(req_bus), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .status(status), .busy(busy));

    typedef struct {
        bit rw; logic [6:0] addr; int len; logic [3:0] bus;
        bit addr_nak; int nak_idx;          // data byte index the slave NAKs, -1 none
        int fault_k; int fault_type;        // CMDR write index; 1 AL, 2 ERR, 3 no irq
        int stall_at;                       // long wr_valid gap after this many bytes
        logic [7:0] d0, d1, d2; logic [2:0] exp_status;
    } vec_t;

    vec_t cur;
    logic [7:0] wdata [256];
    logic [7:0] rdata [256];
    logic [7:0] cmd_log[$], dpr_log[$], csr_log[$], rd_log[$];
    logic [7:0] exp_cmd[$], exp_dpr[$], exp_csr[$], exp_rd[$];
    logic [2:0] exp_status, got_status;
    logic [7:0] resp;
    int exp_wr, m_idx, wr_cnt, done_cnt, widx, stall_until;
    int cyc_n, cmd_cyc, done_cyc, dly, cmd_idx, n01, ridx, irq_cnt;
    int checks = 0, failures = 0;

    initial forever #5 clk = ~clk;
    initial begin cyc_n = 0; forever begin @(posedge clk); cyc_n++; end end
    initial begin #900000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        int bad;
        bad = (got.size() != exp.size()) ? 0 : -1;
        for (int i = 0; i < got.size() && i < exp.size() && bad < 0; i++)
            if (got[i] !== exp[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            if (bad < got.size() && bad < exp.size())
                $display("FAIL %s: size %0d/%0d, byte %0d got %0h, expected %0h",
                         name, got.size(), exp.size(), bad, got[bad], exp[bad]);
            else
                $display("FAIL %s: got %0d bytes, expected %0d bytes", name, got.size(), exp.size());
        end
    endtask

    // Transaction model: one CMDR write per command, ending early on AL/ERR/timeout
    function automatic bit issue(input logic [7:0] c, input bit has_d, input logic [7:0] d);
        exp_cmd.push_back(c);
        if (has_d) exp_dpr.push_back(d);
        m_idx++;
        if (m_idx - 1 != cur.fault_k) return 1'b0;
        case (cur.fault_type)
            1: exp_status = 3'd3;
            2: exp_status = 3'd4;
            3: begin exp_status = 3'd5; exp_csr.push_back(8'h00); exp_csr.push_back(8'hC0); end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic void build_expected();
        exp_cmd.delete(); exp_dpr.delete(); exp_csr.delete(); exp_rd.delete();
        exp_status = 3'd0; m_idx = 0; exp_wr = 0;
        if (issue(8'h06, 1, 8'(cur.bus))) return;
        if (issue(8'h04, 0, 8'h00)) return;
        if (issue(8'h01, 1, {cur.addr, cur.rw})) return;
        if (cur.addr_nak) exp_status = 3'd1;
        else for (int i = 0; i < cur.len; i++) begin
            if (!cur.rw) begin
                exp_wr++;
                if (issue(8'h01, 1, wdata[i])) return;
                if (i == cur.nak_idx) begin exp_status = 3'd2; break; end
            end else begin
                if (issue((i == cur.len - 1) ? 8'h03 : 8'h02, 0, 8'h00)) return;
                exp_rd.push_back(rdata[i]);
            end
        end
        void'(issue(8'h05, 0, 8'h00));
    endfunction

    // IICMB register model plus output monitors
    initial begin
        ack_i = 0; irq_i = 0; dat_i = 0; dly = 0; irq_cnt = 0;
        forever begin
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                wr_cnt++; widx++;
                if (widx == cur.stall_at) stall_until = cyc_n + 250;
            end
            if (rd_valid) rd_log.push_back(rd_data);
            if (done) begin done_cnt++; got_status = status; done_cyc = cyc_n; end
            if (ack_i) ack_i = 0;
            else if (cyc_o && stb_o) begin
                if (dly > 0) dly--;
                else begin
                    if (we_o) begin
                        if (adr_o == 2'd0) csr_log.push_back(dat_o);
                        else if (adr_o == 2'd1) dpr_log.push_back(dat_o);
                        else if (adr_o == 2'd2) begin
                            cmd_log.push_back(dat_o); cmd_cyc = cyc_n; resp = 8'h80;
                            if (cmd_idx == cur.fault_k && cur.fault_type == 1) resp = 8'h60;
                            else if (cmd_idx == cur.fault_k && cur.fault_type == 2) resp = 8'h50;
                            else if (dat_o == 8'h01) begin
                                if (n01 == 0 && cur.addr_nak) resp = 8'hC0;
                                else if (n01 > 0 && !cur.rw && n01 - 1 == cur.nak_idx) resp = 8'hC0;
                                n01++;
                            end
                            if (!(cmd_idx == cur.fault_k && cur.fault_type == 3))
                                irq_cnt = $urandom_range(1, 5);
                            cmd_idx++;
                        end
                    end else if (adr_o == 2'd1) begin
                        dat_i = rdata[ridx % 256]; ridx++;
                    end else if (adr_o == 2'd2) begin
                        dat_i = resp; irq_i = 0;
                    end else dat_i = 8'h00;
                    ack_i = 1; dly = $urandom_range(0, 2);
                end
            end
            if (irq_cnt > 0) begin irq_cnt--; if (irq_cnt == 0) irq_i = 1; end
        end
    end

    // Write-byte source with random gaps
    initial begin
        wr_valid = 0; wr_data = 0;
        forever begin
            @(posedge clk); #1;
            if (!cur.rw && widx < cur.len && cyc_n >= stall_until && $urandom_range(0, 3) != 0) begin
                wr_valid = 1; wr_data = wdata[widx];
            end else wr_valid = 0;
        end
    end

    function automatic vec_t mk(bit rw, logic [6:0] addr, int len, logic [3:0] bus, bit an, int nk,
                                int fk, int ft, int st, logic [7:0] d0, d1, d2, logic [2:0] es);
        vec_t v;
        v.rw = rw; v.addr = addr; v.len = len; v.bus = bus; v.addr_nak = an; v.nak_idx = nk;
        v.fault_k = fk; v.fault_type = ft; v.stall_at = st; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.exp_status = es;
        return v;
    endfunction

    task automatic clear_model();
        cmd_log.delete(); dpr_log.delete(); csr_log.delete(); rd_log.delete();
        wr_cnt = 0; done_cnt = 0; widx = 0; stall_until = 0; cmd_idx = 0; n01 = 0; ridx = 0;
    endtask

    task automatic start_request(input vec_t v);
        int t;
        cur = v;
        for (int i = 0; i < 256; i++) begin wdata[i] = 8'($urandom); rdata[i] = 8'($urandom); end
        wdata[0] = v.d0; wdata[1] = v.d1; wdata[2] = v.d2;
        rdata[0] = v.d0; rdata[1] = v.d1; rdata[2] = v.d2;
        clear_model();
        build_expected();
        t = 0;
        while (!req_ready && t < 1000) begin @(negedge clk); t++; end
        check("req_ready_before_request", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1; req_rw = v.rw; req_addr = v.addr; req_len = 8'(v.len); req_bus = v.bus;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic finish_request(input bit use_tab);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("done_pulse_count", 64'(done_cnt), 1);
        check("status", got_status, exp_status);
        if (use_tab) check("status_table", got_status, cur.exp_status);
        check_q("cmdr_writes", cmd_log, exp_cmd);
        check_q("dpr_writes", dpr_log, exp_dpr);
        check_q("csr_writes", csr_log, exp_csr);
        check_q("read_bytes", rd_log, exp_rd);
        check("wr_accepts", 64'(wr_cnt), 64'(exp_wr));
        if (exp_status == 3'd5) check("timeout_latency", 64'(done_cyc - cmd_cyc >= 100), 1);
    endtask

    vec_t tv[11];
    vec_t v;
    logic [7:0] q_c0[$];

    initial begin
        int t;
        cur = mk(1, 0, 0, 0, 0, -1, -1, 0, -1, 0, 0, 0, 0);
        rst_i = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_len = 0; req_bus = 0;
        clear_model();
        q_c0.push_back(8'hC0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cyc_o, stb_o, we_o, req_ready, wr_ready, rd_valid, done, busy,
                                adr_o, dat_o, rd_data, status}, 0);
        @(posedge clk); #1; rst_i = 0;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        check_q("init_csr", csr_log, q_c0);
        check("idle_outputs", {req_ready, busy, cyc_o, done, rd_valid, wr_ready}, 6'b100000);

        tv[0]  = mk(0, 7'h22, 3,   0, 0, -1, -1, 0, -1, 8'hA5, 8'h5A, 8'hFF, 3'd0);
        tv[1]  = mk(1, 7'h22, 2,   0, 0, -1, -1, 0, -1, 8'h11, 8'h22, 8'h33, 3'd0);
        tv[2]  = mk(0, 7'h10, 0,   1, 1, -1, -1, 0, -1, 8'h00, 8'h00, 8'h00, 3'd1);
        tv[3]  = mk(0, 7'h33, 4,   2, 0,  1, -1, 0, -1, 8'h01, 8'h02, 8'h03, 3'd2);
        tv[4]  = mk(1, 7'h44, 2,   3, 0, -1,  2, 1, -1, 8'h00, 8'h00, 8'h00, 3'd3);
        tv[5]  = mk(0, 7'h55, 3,   4, 0, -1,  4, 2,  1, 8'h10, 8'h20, 8'h30, 3'd4);
        tv[6]  = mk(0, 7'h66, 1,   5, 0, -1,  0, 3, -1, 8'h00, 8'h00, 8'h00, 3'd5);
        tv[7]  = mk(1, 7'h77, 2,   6, 0, -1,  3, 3, -1, 8'h00, 8'h00, 8'h00, 3'd5);
        tv[8]  = mk(1, 7'h08, 255, 7, 0, -1, -1, 0, -1, 8'hDE, 8'hAD, 8'hBE, 3'd0);
        tv[9]  = mk(1, 7'h09, 0,   8, 0, -1, -1, 0, -1, 8'h00, 8'h00, 8'h00, 3'd0);
        tv[10] = mk(0, 7'h0A, 3,   9, 0, -1, -1, 0,  2, 8'hC3, 8'h3C, 8'h99, 3'd0);
        for (int i = 0; i < 11; i++) begin
            start_request(tv[i]);
            finish_request(1);
        end

        // Reset in the middle of a data byte, then a clean request
        start_request(mk(0, 7'h41, 4, 2, 0, -1, -1, 0, -1, 8'h01, 8'h02, 8'h03, 3'd0));
        t = 0;
        while (!(cmd_log.size() >= 4 && cyc_o) && t < 2000) begin @(negedge clk); t++; end
        check("midreset_reached_data", 64'(cmd_log.size() >= 4), 1);
        @(posedge clk); #1; rst_i = 1;
        @(posedge clk); #1;
        check("midreset_cyc_busy", {cyc_o, stb_o, busy, done}, 0);
        clear_model(); ack_i = 0; irq_i = 0; irq_cnt = 0; dly = 0;
        @(posedge clk); #1; rst_i = 0;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check_q("midreset_reinit_csr", csr_log, q_c0);
        start_request(mk(0, 7'h22, 3, 0, 0, -1, -1, 0, -1, 8'hA5, 8'h5A, 8'hFF, 3'd0));
        finish_request(1);

        for (int n = 0; n < 40; n++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(7, 20)) : int'($urandom_range(0, 6));
            v = mk(1'($urandom_range(0, 1)), 7'($urandom), len, 4'($urandom),
                   $urandom_range(0, 7) == 0,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1,
                   -1, 0, -1, 8'($urandom), 8'($urandom), 8'($urandom), 3'd0);
            if ($urandom_range(0, 5) == 0) begin
                v.fault_k = $urandom_range(0, len + 4);
                v.fault_type = $urandom_range(1, 3);
            end
            start_request(v);
            finish_request(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2cmb_wb_sequencer.md
Name: i2cmb_wb_sequencer

Overview:
- Synthesizable Wishbone master sitting directly upstream of the I2C multi-bus controller (iicmb_m_wb); drives its CSR/DPR/CMDR registers in place of the wb_if BFM.
- Converts one byte-level request (bus, 7-bit address, direction, length) into the full IICMB command sequence: set-bus, start, address, data bytes, stop.
- Handles completion via irq_i, decodes CMDR status and streams read data out.

Parameters:
- LEN_W, 8, width of req_len; max transfer 2**LEN_W-1 bytes.
- BUS_W, 4, width of req_bus (bus ID written to DPR).
- TIMEOUT_CYCLES, 65535, clk_i cycles allowed between CMDR write and irq_i before abort.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- ack_i  in  1  Wishbone acknowledge from DUT
- adr_o  out  2  register offset: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
- we_o  out  1  Wishbone write enable
- dat_o  out  8  write data to DUT
- dat_i  in  8  read data from DUT
- irq_i  in  1  DUT interrupt (command complete)
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE only
- req_rw  in  1  0 write, 1 read
- req_addr  in  7  I2C slave address
- req_len  in  LEN_W  byte count (0 = address probe)
- req_bus  in  BUS_W  target I2C bus
- wr_data  in  8  write byte
- wr_valid  in  1  write byte valid
- wr_ready  out  1  write byte accepted this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse per read byte, no backpressure
- done  out  1  one-cycle pulse at end of request
- status  out  3  result, valid when done=1
- busy  out  1  high outside IDLE

Behaviour:
- Reset (rst_i=1 at clk_i edge): state INIT; cyc_o/stb_o/we_o/req_ready/wr_ready/rd_valid/done/busy=0; adr_o=0, dat_o=0, rd_data=0, status=0. Applies mid-transaction: Wishbone cycle dropped on next edge, no stop issued.
- WB micro-op: cyc_o=stb_o=1 with adr/we/dat held stable until the cycle ack_i=1; deassert on next edge; reads latch dat_i on the ack cycle. One op in flight; never back-to-back without one idle cycle.
- INIT: write CSR=0xC0 (enable + interrupt enable), then IDLE.
- IDLE: req_ready=1; request accepted on req_valid&req_ready; all fields latched; byte counter = req_len.
- Command step CMD(c, d): optional WB write DPR=d; WB write CMDR=c; WAIT_IRQ; WB read CMDR (clears irq). Decode bits: [7] DON, [6] NAK, [5] AL, [4] ERR; priority AL > ERR > NAK.
- Sequence: CMD(0x06, req_bus) set-bus; CMD(0x04) start; CMD(0x01, {req_addr, req_rw}) address; per byte: write -> wait wr_valid, wr_ready=1 for exactly one cycle, CMD(0x01, wr_data); read -> CMD(0x02) ACK, or CMD(0x03) NAK on last byte, then WB read DPR, rd_valid pulse next cycle; CMD(0x05) stop; DONE.
- DONE: done=1 for one cycle, status driven, return to IDLE next cycle.
- status: 0 OK; 1 address NAK; 2 data NAK (write); 3 arbitration lost; 4 ERR; 5 timeout.
- Address NAK or data NAK: skip remaining bytes, issue stop, then DONE with code.
- AL or ERR: no stop issued (controller already idle); DONE immediately.
- Timeout: counter loads TIMEOUT_CYCLES on CMDR write, decrements in WAIT_IRQ; at 0 -> write CSR=0x00 then CSR=0xC0 (controller reset), DONE status 5.
- req_len=0: start, address, stop only (probe).
- Write stall: wr_valid low holds the sequencer with the I2C bus owned (SCL held by controller); no timeout while waiting for wr_valid.
- irq_i sampled only in WAIT_IRQ; stray irq elsewhere ignored.
- Counter wrap: byte counter never decrements below 0; req_len=2**LEN_W-1 supported.

Test Plan:
- Reset then idle -> exactly one WB write adr=0 dat=0xC0; req_ready=1 afterwards; all other outputs 0.
- Write bus=0, addr=0x22, len=3, bytes 0xA5,0x5A,0xFF, slave ACKs all -> CMDR writes 0x06,0x04,0x01x4,0x05; DPR writes 0x00,0x44,0xA5,0x5A,0xFF; done with status=0.
- Read addr=0x22, len=2, slave returns 0x11,0x22 -> CMDR writes 0x02 then 0x03; DPR first write 0x45; rd_valid pulses with 0x11 then 0x22; status=0.
- Probe addr=0x10, len=0, no slave -> address NAK; stop issued; done status=1; no wr_ready or rd_valid pulse.
- Irq forced low with TIMEOUT_CYCLES=100 -> done status=5 no earlier than 100 cycles after the CMDR write; CSR written 0x00 then 0xC0.
- rst_i asserted mid data byte -> cyc_o=0 next edge, busy=0, then CSR=0xC0 re-init; next request completes with status=0.
